// File: rtl/term_pkg.sv
// Shared constants and types for the text-terminal write engine.
package term_pkg;

    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] TAB      = 8'h09;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] FF       = 8'h0C;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] CLR_CHAR = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        CLS
    } term_state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_term_ctrl_if.sv
// Byte input handshake plus character-buffer write port of the terminal engine.
interface text_term_ctrl_if #(
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
);
    logic                   ch_valid;
    logic [7:0]             ch_data;
    logic                   ch_ready;
    logic                   wr_en;
    logic [COL_W+ROW_W-1:0] wr_addr;
    logic [7:0]             wr_data;

    // master: byte source that also observes the buffer writes
    modport master (
        output ch_valid,
        output ch_data,
        input  ch_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        output ch_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/term_clear_seq.sv
// Column/row counter producing the clear-burst addresses: one row, or every ring row.
module term_clear_seq #(
    parameter int unsigned COLS  = 70,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             full,
    input  logic [ROW_W-1:0] start_row,
    output logic             active,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             done
);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic             active_q;
    logic             full_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    assign active = active_q;
    assign col    = col_q;
    assign row    = row_q;
    assign done   = active_q && (col_q == LAST_COL) && (!full_q || (&row_q));

    // Reset lands in a full-ring sweep, matching the engine entering CLS.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b1;
            full_q   <= 1'b1;
            col_q    <= '0;
            row_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            full_q   <= full;
            col_q    <= '0;
            row_q    <= full ? '0 : start_row;
        end else if (active_q) begin
            if (col_q == LAST_COL) begin
                col_q <= '0;
                if (done) begin
                    active_q <= 1'b0;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_term_ctrl.sv
// Text-terminal write engine: cursor, wrap, line-end table, backspace, tab,
// clear-screen and ring-buffer scrolling into a dual-port character buffer.
module text_term_ctrl
    import term_pkg::*;
#(
    parameter int unsigned COLS  = 70,
    parameter int unsigned ROWS  = 30,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned TAB   = 8
) (
    input  logic             clk,
    input  logic             reset,
    text_term_ctrl_if.slave  bus,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic [ROW_W-1:0] row_offset,
    output logic             busy
);
    localparam int unsigned      DEPTH     = 2 ** ROW_W;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W:0]   FULL_LINE = (COL_W + 1)'(COLS);
    localparam logic [COL_W:0]   TAB_MASK  = ~((COL_W + 1)'(TAB - 1));
    localparam logic [COL_W:0]   TAB_STEP  = (COL_W + 1)'(TAB);

    term_state_e            state_q;
    logic                   ready_q;
    logic                   tail_q;
    logic                   wr_en_q;
    logic [COL_W+ROW_W-1:0] wr_addr_q;
    logic [7:0]             wr_data_q;
    logic [COL_W:0]         line_end [DEPTH];

    logic             accept;
    logic [ROW_W-1:0] phys_cur;
    logic [ROW_W-1:0] phys_prev;
    logic [COL_W:0]   prev_end;
    logic [COL_W:0]   tab_sum;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;
    logic [ROW_W-1:0] off_d;
    logic             wr_d;
    logic [COL_W-1:0] wcol_d;
    logic [ROW_W-1:0] wrow_d;
    logic [7:0]       wdata_d;
    logic             le_we;
    logic [COL_W:0]   le_val;
    logic             adv;
    logic             go_clear;
    logic             go_cls;

    logic             seq_start;
    logic [ROW_W-1:0] seq_row_in;
    logic             seq_active;
    logic [COL_W-1:0] seq_col;
    logic [ROW_W-1:0] seq_row;
    logic             seq_done;

    assign bus.ch_ready = ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    always_comb begin
        accept    = (state_q == IDLE) && ready_q && bus.ch_valid;
        phys_cur  = cur_row + row_offset;
        phys_prev = phys_cur - 1'b1;
        prev_end  = line_end[phys_prev];
        tab_sum   = ({1'b0, cur_col} & TAB_MASK) + TAB_STEP;
        col_d     = cur_col;
        row_d     = cur_row;
        off_d     = row_offset;
        wr_d      = 1'b0;
        wcol_d    = cur_col;
        wrow_d    = phys_cur;
        wdata_d   = CLR_CHAR;
        le_we     = 1'b0;
        le_val    = {1'b0, cur_col};
        adv       = 1'b0;
        go_clear  = 1'b0;
        go_cls    = 1'b0;
        if (accept) begin
            if (is_printable(bus.ch_data)) begin
                wr_d    = 1'b1;
                wdata_d = bus.ch_data;
                if (cur_col == LAST_COL) begin
                    le_we  = 1'b1;
                    le_val = FULL_LINE;
                    col_d  = '0;
                    adv    = 1'b1;
                end else begin
                    col_d = cur_col + 1'b1;
                end
            end else begin
                case (bus.ch_data)
                    CR, LF: begin
                        le_we = 1'b1;
                        col_d = '0;
                        adv   = 1'b1;
                    end
                    BS: begin
                        if (cur_col != '0) begin
                            col_d  = cur_col - 1'b1;
                            wr_d   = 1'b1;
                            wcol_d = cur_col - 1'b1;
                        end else if (cur_row != '0) begin
                            row_d = cur_row - 1'b1;
                            // A wrapped line lands the cursor on its last cell and erases it
                            if (prev_end == FULL_LINE) begin
                                col_d  = LAST_COL;
                                wr_d   = 1'b1;
                                wcol_d = LAST_COL;
                                wrow_d = phys_prev;
                            end else begin
                                col_d = prev_end[COL_W-1:0];
                            end
                        end
                    end
                    term_pkg::TAB: begin
                        col_d = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[COL_W-1:0];
                    end
                    FF:      go_cls = 1'b1;
                    default: ;
                endcase
            end
            if (adv) begin
                if (cur_row != LAST_ROW) begin
                    row_d = cur_row + 1'b1;
                end else begin
                    off_d    = row_offset + 1'b1;
                    go_clear = 1'b1;
                end
            end
        end
    end

    assign seq_start  = go_clear || go_cls;
    // New bottom row under the post-scroll offset
    assign seq_row_in = off_d + LAST_ROW;

    term_clear_seq #(
        .COLS (COLS),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .start    (seq_start),
        .full     (go_cls),
        .start_row(seq_row_in),
        .active   (seq_active),
        .col      (seq_col),
        .row      (seq_row),
        .done     (seq_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLS;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
            tail_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= CLR_CHAR;
            cur_col    <= '0;
            cur_row    <= '0;
            row_offset <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                line_end[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_q   <= wr_d;
                    wr_addr_q <= {wcol_d, wrow_d};
                    wr_data_q <= wdata_d;
                    tail_q    <= 1'b0;
                    if (go_cls) begin
                        state_q    <= CLS;
                        ready_q    <= 1'b0;
                        busy       <= 1'b1;
                        cur_col    <= '0;
                        cur_row    <= '0;
                        row_offset <= '0;
                        for (int i = 0; i < DEPTH; i++) begin
                            line_end[i] <= '0;
                        end
                    end else if (accept) begin
                        cur_col    <= col_d;
                        cur_row    <= row_d;
                        row_offset <= off_d;
                        if (le_we) begin
                            line_end[phys_cur] <= le_val;
                        end
                        if (go_clear) begin
                            state_q <= CLEAR;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                CLEAR, CLS: begin
                    wr_en_q   <= seq_active;
                    wr_addr_q <= {seq_col, seq_row};
                    wr_data_q <= CLR_CHAR;
                    // Stay busy through the cycle that shows the final write
                    tail_q    <= seq_done;
                    if (tail_q) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= CLS;
            endcase
        end
    end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Scoreboard bench for text_term_ctrl: a reference model queues every expected buffer write.
module tb_text_term_ctrl;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int COL_W = 7;
    localparam int ROW_W = 5;
    localparam int DEPTH = 32;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b0;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic [4:0] row_offset;
    logic       busy;

    always #10 clk_50m = ~clk_50m;

    text_term_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    text_term_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS),
        .COL_W(COL_W),
        .ROW_W(ROW_W),
        .TAB  (8)
    ) dut (
        .clk       (clk_50m),
        .reset     (reset),
        .bus       (bus),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .row_offset(row_offset),
        .busy      (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    int          m_col, m_row, m_off;
    int          m_le[DEPTH];

    // Scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk_50m) begin
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL wr_seq: got addr %h data %h, required addr %h data %h",
                             bus.wr_addr, bus.wr_data, mon_exp[19:8], mon_exp[7:0]);
                end
            end
        end
    end

    function automatic int phys(input int r);
        return (r + m_off) % DEPTH;
    endfunction

    task automatic push_wr(input int c, input int r, input logic [7:0] d);
        logic [6:0] cc;
        logic [4:0] rr;
        cc = c[6:0];
        rr = r[4:0];
        exp_q.push_back({cc, rr, d});
    endtask

    task automatic model_cls();
        m_col = 0; m_row = 0; m_off = 0;
        for (int i = 0; i < DEPTH; i++) m_le[i] = 0;
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < COLS; c++) push_wr(c, r, 8'h00);
    endtask

    task automatic model_advance();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_off = (m_off + 1) % DEPTH;
            for (int c = 0; c < COLS; c++) push_wr(c, (ROWS - 1 + m_off) % DEPTH, 8'h00);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_col, phys(m_row), b);
            if (m_col == COLS - 1) begin
                m_le[phys(m_row)] = COLS;
                m_col = 0;
                model_advance();
            end else begin
                m_col++;
            end
        end else begin
            case (b)
                8'h0D, 8'h0A: begin
                    m_le[phys(m_row)] = m_col;
                    m_col = 0;
                    model_advance();
                end
                8'h08: begin
                    if (m_col > 0) begin
                        m_col--;
                        push_wr(m_col, phys(m_row), 8'h00);
                    end else if (m_row > 0) begin
                        m_row--;
                        if (m_le[phys(m_row)] == COLS) begin
                            m_col = COLS - 1;
                            push_wr(m_col, phys(m_row), 8'h00);
                        end else begin
                            m_col = m_le[phys(m_row)];
                        end
                    end
                end
                8'h09: begin
                    m_col = (m_col / 8) * 8 + 8;
                    if (m_col > COLS - 1) m_col = COLS - 1;
                end
                8'h0C:   model_cls();
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_50m);
            if (bus.ch_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ch_ready=%b, required 1 before byte %h", bus.ch_ready, b);
            return;
        end
        bus.ch_valid = 1'b1;
        bus.ch_data  = b;
        @(posedge clk_50m);
        #1;
        bus.ch_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_50m);
            if (exp_q.size() == 0 && bus.ch_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, ready=%b, required 0 and 1",
                     name, exp_q.size(), bus.ch_ready);
        end
        checks++;
        if ({cur_col, cur_row, row_offset} !== {m_col[6:0], m_row[4:0], m_off[4:0]}) begin
            errors++;
            $display("FAIL %s_cursor: got col %0d row %0d off %0d, required col %0d row %0d off %0d",
                     name, cur_col, cur_row, row_offset, m_col, m_row, m_off);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_50m);
        reset = 1'b1;
        @(posedge clk_50m);
        #1;
        reset = 1'b0;
        model_cls();
        checks++;
        if ({bus.wr_en, bus.ch_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got wr_en %b ready %b busy %b, required 0 0 1",
                     bus.wr_en, bus.ch_ready, busy);
        end
        checks++;
        if ({cur_col, cur_row, row_offset} !== 17'd0) begin
            errors++;
            $display("FAIL reset_cursor: got %0d %0d %0d, required 0 0 0", cur_col, cur_row, row_offset);
        end
        drain("reset");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        send(8'h41);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h42;
        @(posedge clk_50m);
        #1;
        bus.ch_valid = 1'b0;
        model_byte(8'h42);
        checks++;
        if (cur_col !== 7'd2) begin
            errors++;
            $display("FAIL b2b_col: got %0d, required 2", cur_col);
        end
        drain("b2b");
    endtask

    task automatic test_ignored();
        send(8'h80); send(8'h7F); send(8'h00); send(8'h1B);
        repeat (3) @(negedge clk_50m);
        checks++;
        if ({cur_col, cur_row} !== {7'd2, 5'd0}) begin
            errors++;
            $display("FAIL ignored_cursor: got %0d,%0d, required 2,0", cur_col, cur_row);
        end
        drain("ignored");
    endtask

    task automatic test_wrap_backspace();
        send(8'h0C);
        checks++;
        if ({busy, bus.ch_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ff_busy: got busy %b ready %b, required 1 0", busy, bus.ch_ready);
        end
        drain("ff");
        for (int i = 0; i < 71; i++) send(8'h78);
        checks++;
        if ({cur_col, cur_row} !== {7'd1, 5'd1}) begin
            errors++;
            $display("FAIL wrap_cursor: got %0d,%0d, required 1,1", cur_col, cur_row);
        end
        send(8'h08);
        checks++;
        if ({cur_col, cur_row} !== {7'd0, 5'd1}) begin
            errors++;
            $display("FAIL bs1_cursor: got %0d,%0d, required 0,1", cur_col, cur_row);
        end
        send(8'h08);
        checks++;
        if ({cur_col, cur_row} !== {7'd69, 5'd0}) begin
            errors++;
            $display("FAIL bs_wrapline: got %0d,%0d, required 69,0", cur_col, cur_row);
        end
        send(8'h08);
        send(8'h0D);
        send(8'h08);
        checks++;
        if ({cur_col, cur_row} !== {7'd68, 5'd0}) begin
            errors++;
            $display("FAIL bs_shortline: got %0d,%0d, required 68,0", cur_col, cur_row);
        end
        drain("bs");
    endtask

    task automatic test_tab();
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h79);
        send(8'h09);
        checks++;
        if (cur_col !== 7'd8) begin
            errors++;
            $display("FAIL tab_5: got %0d, required 8", cur_col);
        end
        for (int i = 0; i < 58; i++) send(8'h7A);
        send(8'h09);
        checks++;
        if (cur_col !== 7'd69) begin
            errors++;
            $display("FAIL tab_66: got %0d, required 69", cur_col);
        end
        send(8'h09);
        checks++;
        if ({cur_col, cur_row} !== {7'd69, 5'd1}) begin
            errors++;
            $display("FAIL tab_69: got %0d,%0d, required 69,1", cur_col, cur_row);
        end
        send(8'h0C);
        checks++;
        if ({busy, cur_col, cur_row} !== {1'b1, 7'd0, 5'd0}) begin
            errors++;
            $display("FAIL ff_midline: got busy %b %0d,%0d, required 1 0,0", busy, cur_col, cur_row);
        end
        drain("ff_mid");
        send(8'h08);
        repeat (3) @(negedge clk_50m);
        checks++;
        if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
            errors++;
            $display("FAIL bs_origin: got %0d,%0d, required 0,0", cur_col, cur_row);
        end
        drain("bs_origin");
    endtask

    task automatic test_scroll();
        bit   acc;
        logic r;
        int   lows;
        bit   seen;
        for (int i = 0; i < ROWS - 1; i++) send(8'h0D);
        checks++;
        if ({cur_row, row_offset} !== {5'd29, 5'd0}) begin
            errors++;
            $display("FAIL row29: got row %0d off %0d, required 29 0", cur_row, row_offset);
        end
        send(8'h0D);
        checks++;
        if ({row_offset, cur_row, bus.ch_ready, busy} !== {5'd1, 5'd29, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL scroll1: got off %0d row %0d ready %b busy %b, required 1 29 0 1",
                     row_offset, cur_row, bus.ch_ready, busy);
        end
        // Offer a byte while not ready; it must be held, then accepted after the clear
        acc  = 1'b0;
        lows = 0;
        @(negedge clk_50m);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h51;
        for (int i = 0; i < 300 && !acc; i++) begin
            r = bus.ch_ready;
            @(posedge clk_50m);
            #1;
            if (r === 1'b1) acc = 1'b1;
            else begin
                lows++;
                @(negedge clk_50m);
            end
        end
        bus.ch_valid = 1'b0;
        if (acc) model_byte(8'h51);
        checks++;
        if (!acc || lows < COLS) begin
            errors++;
            $display("FAIL hold_byte: accepted %b after %0d not-ready cycles, required 1 after >= 70",
                     acc, lows);
        end
        drain("hold");
        for (int i = 0; i < COLS - 1; i++) send(8'h77);
        checks++;
        if ({row_offset, cur_col, cur_row, bus.ch_ready} !== {5'd2, 7'd0, 5'd29, 1'b0}) begin
            errors++;
            $display("FAIL wrap_scroll: got off %0d %0d,%0d ready %b, required 2 0,29 0",
                     row_offset, cur_col, cur_row, bus.ch_ready);
        end
        drain("wrap_scroll");
        while (m_off != DEPTH - 1 && errors < 20) send(8'h0D);
        drain("off31");
        send(8'h0D);
        checks++;
        if (row_offset !== 5'd0) begin
            errors++;
            $display("FAIL off_wrap: got %0d, required 0", row_offset);
        end
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk_50m);
            if (bus.wr_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.wr_addr !== 12'h01D) begin
            errors++;
            $display("FAIL wrap_clear_row: got wr_en %b addr %h, required 1 01d", bus.wr_en, bus.wr_addr);
        end
        drain("off_wrap");
    endtask

    initial begin
        bus.ch_valid = 1'b0;
        bus.ch_data  = 8'h00;
        test_reset();
        test_back_to_back();
        test_ignored();
        test_wrap_backspace();
        test_tab();
        test_scroll();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
